// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: issue at tail, result capture from two buses,
// single commit per cycle at head, and a one-cycle flush after a mispredicted branch.
module reorder_buffer #(
    parameter int ROB_SIZE_BIT = 3,
    parameter int ROB_TYPE_BIT = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    issue_valid,
    input  logic                    issue_fi,
    input  logic [31:0]             issue_value,
    input  logic [31:0]             issue_addr,
    input  logic [ROB_TYPE_BIT-1:0] issue_type,
    input  logic [4:0]              issue_rd,
    output logic                    rob_full,
    output logic [ROB_SIZE_BIT-1:0] rob_vacant_id,
    output logic                    rob_clear,
    output logic [31:0]             redirect_pc,
    input  logic [ROB_SIZE_BIT-1:0] q1_id,
    input  logic [ROB_SIZE_BIT-1:0] q2_id,
    output logic                    q1_fi,
    output logic                    q2_fi,
    output logic [31:0]             q1_value,
    output logic [31:0]             q2_value,
    input  logic                    rs_cdb_valid,
    input  logic [ROB_SIZE_BIT-1:0] rs_cdb_id,
    input  logic [31:0]             rs_cdb_value,
    input  logic                    lsb_cdb_valid,
    input  logic [ROB_SIZE_BIT-1:0] lsb_cdb_id,
    input  logic [31:0]             lsb_cdb_value,
    output logic                    commit_valid,
    output logic [4:0]              commit_rd,
    output logic [31:0]             commit_value,
    output logic [ROB_SIZE_BIT-1:0] commit_id,
    output logic                    store_commit
);
    localparam int N = 1 << ROB_SIZE_BIT;
    localparam logic [ROB_TYPE_BIT-1:0] TYPE_BR  = ROB_TYPE_BIT'(2);
    localparam logic [ROB_TYPE_BIT-1:0] TYPE_ST  = ROB_TYPE_BIT'(3);
    localparam logic [ROB_SIZE_BIT-1:0] ID_ONE   = ROB_SIZE_BIT'(1);
    localparam logic [ROB_SIZE_BIT:0]   CNT_ONE  = (ROB_SIZE_BIT+1)'(1);
    localparam logic [ROB_SIZE_BIT:0]   FULL_CNT = (ROB_SIZE_BIT+1)'(N);

    logic [ROB_SIZE_BIT-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_SIZE_BIT:0]   count_q, count_d;
    logic [N-1:0]            busy_q, busy_d, ready_q, ready_d;
    logic [ROB_TYPE_BIT-1:0] type_q [N];
    logic [ROB_TYPE_BIT-1:0] type_d [N];
    logic [4:0]              rd_q [N];
    logic [4:0]              rd_d [N];
    logic [31:0]             value_q [N];
    logic [31:0]             value_d [N];
    logic [31:0]             addr_q [N];
    logic [31:0]             addr_d [N];

    logic                    rob_clear_q, rob_clear_d, commit_valid_q, commit_valid_d;
    logic                    store_commit_q, store_commit_d;
    logic [31:0]             redirect_pc_q, redirect_pc_d, commit_value_q, commit_value_d;
    logic [4:0]              commit_rd_q, commit_rd_d;
    logic [ROB_SIZE_BIT-1:0] commit_id_q, commit_id_d;
    logic                    commit_do, issue_do, rs_ok, lsb_ok;

    // Results for entries that are no longer (or not yet) allocated are dropped.
    assign rs_ok  = rs_cdb_valid && busy_q[rs_cdb_id];
    assign lsb_ok = lsb_cdb_valid && busy_q[lsb_cdb_id];

    // The decoder sees the slot state one issue ahead because issue lags decode by a cycle.
    assign rob_full      = (count_q + (ROB_SIZE_BIT+1)'(issue_valid)) >= FULL_CNT;
    assign rob_vacant_id = tail_q + ROB_SIZE_BIT'(issue_valid);

    logic [ROB_SIZE_BIT-1:0] q_id [2];
    logic [1:0]              q_fi;
    logic [1:0][31:0]        q_value;
    assign q_id[0]  = q1_id;
    assign q_id[1]  = q2_id;
    assign q1_fi    = q_fi[0];
    assign q2_fi    = q_fi[1];
    assign q1_value = q_value[0];
    assign q2_value = q_value[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_query
            logic rs_hit, lsb_hit;
            assign rs_hit      = rs_ok && (rs_cdb_id == q_id[gi]);
            assign lsb_hit     = lsb_ok && (lsb_cdb_id == q_id[gi]);
            assign q_fi[gi]    = ready_q[q_id[gi]] || rs_hit || lsb_hit;
            assign q_value[gi] = lsb_hit ? lsb_cdb_value :
                                 rs_hit  ? rs_cdb_value  : value_q[q_id[gi]];
        end
    endgenerate

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        busy_d         = busy_q;
        ready_d        = ready_q;
        type_d         = type_q;
        rd_d           = rd_q;
        value_d        = value_q;
        addr_d         = addr_q;
        rob_clear_d    = rob_clear_q;
        redirect_pc_d  = redirect_pc_q;
        commit_valid_d = commit_valid_q;
        store_commit_d = store_commit_q;
        commit_rd_d    = commit_rd_q;
        commit_value_d = commit_value_q;
        commit_id_d    = commit_id_q;
        commit_do      = 1'b0;
        issue_do       = 1'b0;
        if (rdy_in) begin
            rob_clear_d    = 1'b0;
            commit_valid_d = 1'b0;
            store_commit_d = 1'b0;
            if (rob_clear_q) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                busy_d  = '0;
            end else begin
                if (rs_ok) begin
                    ready_d[rs_cdb_id] = 1'b1;
                    value_d[rs_cdb_id] = rs_cdb_value;
                end
                if (lsb_ok) begin
                    ready_d[lsb_cdb_id] = 1'b1;
                    value_d[lsb_cdb_id] = lsb_cdb_value;
                end
                if (count_q != '0 && ready_q[head_q]) begin
                    commit_do       = 1'b1;
                    busy_d[head_q]  = 1'b0;
                    head_d          = head_q + ID_ONE;
                    commit_id_d     = head_q;
                    commit_rd_d     = rd_q[head_q];
                    commit_value_d  = value_q[head_q];
                    case (type_q[head_q])
                        TYPE_ST: store_commit_d = 1'b1;
                        // Branch outcome sits in value bit 0, prediction in rd bit 0.
                        TYPE_BR: if (value_q[head_q][0] != rd_q[head_q][0]) begin
                            rob_clear_d   = 1'b1;
                            redirect_pc_d = addr_q[head_q];
                        end
                        default: commit_valid_d = 1'b1;
                    endcase
                end
                issue_do = issue_valid && (!count_q[ROB_SIZE_BIT] || commit_do);
                if (issue_do) begin
                    busy_d[tail_q]  = 1'b1;
                    ready_d[tail_q] = issue_fi;
                    type_d[tail_q]  = issue_type;
                    rd_d[tail_q]    = issue_rd;
                    value_d[tail_q] = issue_value;
                    addr_d[tail_q]  = issue_addr;
                    tail_d          = tail_q + ID_ONE;
                end
                if (issue_do && !commit_do) begin
                    count_d = count_q + CNT_ONE;
                end else if (!issue_do && commit_do) begin
                    count_d = count_q - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            ready_q        <= '0;
            rob_clear_q    <= 1'b0;
            redirect_pc_q  <= '0;
            commit_valid_q <= 1'b0;
            store_commit_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_id_q    <= '0;
            for (int i = 0; i < N; i++) begin
                type_q[i]  <= '0;
                rd_q[i]    <= '0;
                value_q[i] <= '0;
                addr_q[i]  <= '0;
            end
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            type_q         <= type_d;
            rd_q           <= rd_d;
            value_q        <= value_d;
            addr_q         <= addr_d;
            rob_clear_q    <= rob_clear_d;
            redirect_pc_q  <= redirect_pc_d;
            commit_valid_q <= commit_valid_d;
            store_commit_q <= store_commit_d;
            commit_rd_q    <= commit_rd_d;
            commit_value_q <= commit_value_d;
            commit_id_q    <= commit_id_d;
        end
    end

    assign rob_clear    = rob_clear_q;
    assign redirect_pc  = redirect_pc_q;
    assign commit_valid = commit_valid_q;
    assign store_commit = store_commit_q;
    assign commit_rd    = commit_rd_q;
    assign commit_value = commit_value_q;
    assign commit_id    = commit_id_q;
endmodule
